// File: rtl/comm_pkg.sv
// Shared definitions for the UART link: TX state encoding, default line settings and baud divisor helper.
// Pure definitions; no timing or flow-control behaviour of its own.
package comm_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;

  localparam int DEFAULT_CLK_FREQ = 100_000_000;
  localparam int DEFAULT_BAUD     = 115_200;

  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running bit-period counter: one-cycle tick on the last cycle of each CLKS_PER_BIT period.
// Tick appears CLKS_PER_BIT-1 cycles after clear drops; clear holds it at zero, no backpressure.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_byte_tx.sv
// UART byte transmitter (start, LSB-first data, even parity under UART_TX_PARITY_EN, stop); line starts one cycle after handshake.
// tx_ready is low for the whole frame; requests during a frame are dropped, not queued.
module uart_byte_tx
  import comm_pkg::*;
#(
  parameter int CLK_FREQ  = DEFAULT_CLK_FREQ,
  parameter int BAUD      = DEFAULT_BAUD,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_serial,
  output logic                 busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
  // Stop bits reuse the data bit index as their counter.
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  uart_tx_state_t       state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 serial_q, serial_d;
  logic                 ready_q, ready_d;
  logic                 tick;
  logic                 handshake;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  assign handshake = tx_valid && ready_q;
  assign tx_ready  = ready_q;
  assign tx_serial = serial_q;
  assign busy      = (state_q != IDLE);

  baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk   (clk),
    .reset (reset),
    .clear (state_q == IDLE),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      serial_q <= 1'b1;
      ready_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      serial_q <= serial_d;
      ready_q  <= ready_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (handshake) begin
          shift_d = tx_data;
          idx_d   = '0;
          state_d = START;
`ifdef UART_TX_PARITY_EN
          parity_d = ^tx_data;
`endif
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (idx_q == LAST_DATA) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_d = STOP;
          idx_d   = '0;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (idx_q == LAST_STOP) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line and ready are registered from the next state so they switch on the same edge as the FSM.
    serial_d = 1'b1;
    case (state_d)
      START:   serial_d = 1'b0;
      DATA:    serial_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  serial_d = parity_d;
`endif
      default: serial_d = 1'b1;
    endcase
    ready_d = (state_d == IDLE);
  end

endmodule

// File: doc/uart_byte_tx.md
Name: uart_byte_tx

Overview:
- Byte-level UART transmitter: the responder end of the tx_valid/tx_ready channel driven by communication_control.
- Accepts one 8-bit word per handshake and serialises it onto the robot's wireless/UART link as start bit, data LSB-first, optional parity, then stop bit(s).
- tx_ready is this block's answer to the controller's tx_valid.
- Sits between communication_control and the top-level UART TX pin.

Parameters:
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD, 115200: line rate in bit/s. CLKS_PER_BIT = CLK_FREQ/BAUD, integer division, 868 at defaults. Must be ≥ 2.
- DATA_BITS, 8: payload bits per frame, range 5..8.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset. reset==0 at a rising edge resets the block.
- tx_valid  in  1  producer has a byte on tx_data.
- tx_data  in  DATA_BITS  byte to send. Sampled only on handshake.
- tx_ready  out  1  block can accept a byte this cycle.
- tx_serial  out  1  serial line, idle high.
- busy  out  1  a frame is in progress (any state other than IDLE).

Behaviour:
- Reset values (reset low at clock edge): state=IDLE, tx_serial=1, tx_ready=1, busy=0, baud counter=0, bit index=0, shift register=0.
- Handshake: a transfer occurs on an edge where tx_valid && tx_ready.
  - tx_ready is high exactly when state==IDLE and the block is not in reset; it is registered.
  - tx_valid while tx_ready is low is ignored and not queued. The producer holds tx_valid until it sees the handshake.
- FSM states and transitions:
  - IDLE: tx_serial=1. On handshake, latch tx_data into the shift register, clear the baud counter, go to START. tx_ready and busy change on the same edge.
  - START: tx_serial=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx_serial = shift register bit 0. Each CLKS_PER_BIT, shift right and increment the index. After bit DATA_BITS-1 completes, go to PARITY (if enabled) or STOP.
  - STOP: tx_serial=1 for STOP_BITS*CLKS_PER_BIT cycles, then go to IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 on the bit-end tick.
  - Width is $clog2(CLKS_PER_BIT).
  - Bit index width is $clog2(DATA_BITS).
- Timing:
  - The start bit begins on the cycle after the handshake edge.
  - Total frame length is (1+DATA_BITS+parity+STOP_BITS)*CLKS_PER_BIT cycles.
  - tx_ready rises on the edge that ends the last stop cycle. A handshake that same cycle is impossible, since tx_ready was low.
  - Back-to-back minimum: the next start bit begins one cycle after tx_ready is seen high and the handshake is taken.
- Simultaneous events:
  - reset low overrides everything, including a pending handshake.
  - Reset mid-frame truncates the frame immediately: the line returns high next edge, with no partial stop-bit guarantee.
- tx_serial is driven from a flop (glitch-free). No combinational path from inputs to tx_serial.
- tx_data changes after the handshake do not affect the frame in flight.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP, lasting CLKS_PER_BIT cycles.
  - tx_serial = even parity = XOR of the latched data bits, computed at latch time and stored in a flop.
  - Frame is lengthened by one bit time.
- Undefined:
  - No PARITY state, no parity flop.
  - DATA goes directly to STOP.

Decomposition:
- Package comm_pkg:
  - typedef enum logic [2:0] uart_tx_state_t {IDLE, START, DATA, PARITY, STOP}.
  - localparam default CLK_FREQ/BAUD.
  - Function clks_per_bit(freq, baud).
  - The package is shared with the future UART receiver and with communication_control.
- Sub-module baud_tick_gen:
  - Parameterised counter with clear input, producing a one-cycle tick at CLKS_PER_BIT.
  - Reused by the receiver at half-bit offset.

Test Plan (bench uses CLK_FREQ=1000, BAUD=100, so CLKS_PER_BIT=10; 10 ns clock):
- Reset: hold reset=0 for 3 cycles with tx_valid=1 -> tx_serial=1, tx_ready=1, busy=0 throughout. No frame starts until reset=1.
- Single byte: tx_data=8'hA5 with a one-cycle handshake -> tx_ready and busy toggle on the next edge; line shows 0 then bits 1,0,1,0,0,1,0,1, then 1, each bit 10 cycles. tx_ready returns high after exactly 100 cycles.
- Ignored request: assert tx_valid with tx_data=8'h3C at cycle 40 of the A5 frame -> no effect on the A5 bits. 8'h3C is sent only after tx_ready rises and the handshake completes.
- Back-to-back 8'h00 then 8'hFF with tx_valid held -> start bit of the second frame begins 1 cycle after tx_ready goes high. Line decodes to 00, FF.
- Mid-frame reset: reset=0 at cycle 35 of a 8'h55 frame -> tx_serial=1 and tx_ready=1 on the next edge. A new handshake then sends a complete frame.
- With UART_TX_PARITY_EN: send 8'h07 -> parity bit 1 and a frame of 110 cycles. Send 8'h03 -> parity bit 0.
